swap_reg_file: RTL and testbench

Single-port-write, single-port-read register file with a built-in swap engine that exchanges the contents of two entries without external read/write traffic. A 3-cycle internal sequence moves data through a temporary register. It serves as a general-purpose storage block where two entries occasionally need to be exchanged atomically with respect to the external write port.

---
 rtl/swap_reg_file.sv | 149 ++++++++++++++
 tb/tb_swap_reg_file.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_reg_file.sv
// -----------------------------------------------------------------------------
// swap_reg_file
//   Single-write-port / single-read-port register file with a built-in swap
//   engine. A swap exchanges two entries over three rising edges using an
//   internal temporary register; the external write port is blocked while the
//   swap runs.
//
//   Parameters:
//     ADDR_WIDTH  address width, depth = 2**ADDR_WIDTH
//     DATA_WIDTH  entry width
//
//   Ports:
//     clk         clock, rising-edge
//     reset_n     asynchronous active-low reset
//     we          external write enable (honoured only in IDLE without swap)
//     address_w   external write address
//     data_w      external write data
//     address_r   read address
//     data_r      combinational read data, mem[address_r]
//     address_A   first swap address  (sampled on the swap start edge)
//     address_B   second swap address (sampled on the swap start edge)
//     swap        swap request, level-sampled in IDLE
//
//   Build option:
//     SWAP_REG_FILE_MEM_RESET_EN  when defined, reset_n also clears every
//                                 storage entry; otherwise the storage flops
//                                 have no reset.
//
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   IDLE          | external writes accepted; swap=1 latches A/B and mem[A]
//   MOVE_B_TO_A   | mem[addr_a] <= mem[addr_b]
//   MOVE_TMP_TO_B | mem[addr_b] <= tmp, then back to IDLE
// -----------------------------------------------------------------------------
module swap_reg_file #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] address_r,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic [ADDR_WIDTH-1:0] address_A,
    input  logic [ADDR_WIDTH-1:0] address_B,
    input  logic                  swap
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        MOVE_B_TO_A   = 2'd1,
        MOVE_TMP_TO_B = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_tmp;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;

    logic                  w_start;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_din;

    // All memory updates funnel through one write port: the external port in
    // IDLE, or one of the two swap moves in the busy states. Swap wins over we.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = address_w;
        w_mem_din   = data_w;
        case (r_state)
            IDLE: begin
                if (swap) begin
                    w_start     = 1'b1;
                    w_state_nxt = MOVE_B_TO_A;
                end else if (we) begin
                    w_mem_we = 1'b1;
                end
            end
            MOVE_B_TO_A: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_addr_a;
                w_mem_din   = r_mem[r_addr_b];
                w_state_nxt = MOVE_TMP_TO_B;
            end
            MOVE_TMP_TO_B: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_addr_b;
                w_mem_din   = r_tmp;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Swap operands are captured only on the start edge so later changes on
    // address_A/address_B cannot disturb an exchange in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmp    <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
        end else if (w_start) begin
            r_tmp    <= r_mem[address_A];
            r_addr_a <= address_A;
            r_addr_b <= address_B;
        end
    end

`ifdef SWAP_REG_FILE_MEM_RESET_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end
`endif

    assign data_r = r_mem[address_r];

endmodule

// File: tb/tb_swap_reg_file.sv
module tb_swap_reg_file;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset_n;
    logic          we;
    logic [AW-1:0] address_w;
    logic [DW-1:0] data_w;
    logic [AW-1:0] address_r;
    logic [DW-1:0] data_r;
    logic [AW-1:0] address_A;
    logic [AW-1:0] address_B;
    logic          swap;

    swap_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (we),
        .address_w (address_w),
        .data_w    (data_w),
        .address_r (address_r),
        .data_r    (data_r),
        .address_A (address_A),
        .address_B (address_B),
        .swap      (swap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the array contents plus the pending exchange, expressed
    // as "A gets B's old value at edge 2, B gets A's old value at edge 3".
    logic [DW-1:0] model [DEPTH];
    int            swap_edges_done;   // 0 = no exchange pending
    int            sw_a, sw_b;
    logic [DW-1:0] old_a, old_b;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        swap_edges_done = 0;
`ifdef SWAP_REG_FILE_MEM_RESET_EN
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    endtask

    task automatic model_edge();
        if (swap_edges_done == 0) begin
            if (swap) begin
                sw_a  = int'(address_A);
                sw_b  = int'(address_B);
                old_a = model[sw_a];
                old_b = model[sw_b];
                swap_edges_done = 1;
            end else if (we) begin
                model[address_w] = data_w;
            end
        end else if (swap_edges_done == 1) begin
            model[sw_a] = old_b;
            swap_edges_done = 2;
        end else begin
            model[sw_b] = old_a;
            swap_edges_done = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input int addr);
        address_r = addr[AW-1:0];
        #1;
        check(tag, data_r, model[addr]);
    endtask

    task automatic read_const(input string tag, input int addr, input logic [DW-1:0] exp);
        address_r = addr[AW-1:0];
        #1;
        check(tag, data_r, exp);
    endtask

    task automatic idle_inputs();
        we = 1'b0;
        swap = 1'b0;
    endtask

    task automatic sweep_all(input string tag);
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) read_check(tag, i);
    endtask

    initial begin
        reset_n   = 1'b0;
        we        = 1'b0;
        swap      = 1'b0;
        address_w = '0;
        data_w    = '0;
        address_r = '0;
        address_A = '0;
        address_B = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model_reset();
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef SWAP_REG_FILE_MEM_RESET_EN
        // Storage is not reset in this build; give it a known starting image.
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; address_w = i[AW-1:0]; data_w = '0;
            tick();
        end
        idle_inputs();
`endif

        // Reset image
        read_const("rst_rd0",   0,   8'h00);
        read_const("rst_rd22",  22,  8'h00);
        read_const("rst_rd127", 127, 8'h00);

        // Writes 20..29, checking no bypass before the write edge
        for (int a = 20; a < 30; a++) begin
            we = 1'b1; address_w = a[AW-1:0]; data_w = a[DW-1:0];
            read_check("wr_pre", a);
            tick();
            read_const("wr_post", a, a[DW-1:0]);
        end
        idle_inputs();
        for (int a = 20; a < 30; a++) read_const("rd_back", a, a[DW-1:0]);
        read_const("rd_30", 30, 8'h00);

        // Swap held for three cycles: exactly one exchange
        address_A = 7'd22; address_B = 7'd28; swap = 1'b1;
        tick();
        read_const("hold_e1_a", 22, 8'd22);
        read_const("hold_e1_b", 28, 8'd28);
        tick();
        read_const("hold_e2_a", 22, 8'd28);
        read_const("hold_e2_b", 28, 8'd28);
        tick();
        read_const("hold_e3_a", 22, 8'd28);
        read_const("hold_e3_b", 28, 8'd22);
        swap = 1'b0;
        tick();
        tick();
        read_const("hold_once_a", 22, 8'd28);
        read_const("hold_once_b", 28, 8'd22);
        for (int a = 20; a < 30; a++) read_check("hold_others", a);

        // Restore 22/28 with a single-cycle pulse
        swap = 1'b1; tick(); swap = 1'b0; tick(); tick();
        read_const("restore_a", 22, 8'd22);
        read_const("restore_b", 28, 8'd28);

        // Pulse with concurrent write (dropped) and mid-sequence address change
        address_A = 7'd22; address_B = 7'd28; swap = 1'b1;
        we = 1'b1; address_w = 7'd22; data_w = 8'h55;
        tick();
        swap = 1'b0; address_B = 7'd5;
        address_w = 7'd40; data_w = 8'h66;
        tick();
        tick();
        read_const("pulse_a", 22, 8'd28);
        read_const("pulse_b", 28, 8'd22);
        read_const("pulse_5", 5, 8'h00);
        read_const("busy_wr_drop", 40, 8'h00);
        data_w = 8'h99;
        tick();
        read_const("wr_after_swap", 40, 8'h99);
        idle_inputs();

        // Self-swap
        address_A = 7'd25; address_B = 7'd25; swap = 1'b1;
        tick();
        swap = 1'b0;
        tick();
        tick();
        read_const("self_swap", 25, 8'd25);
        we = 1'b1; address_w = 7'd26; data_w = 8'hAB;
        tick();
        read_const("self_idle_wr", 26, 8'hAB);
        idle_inputs();

        // Reset in MOVE_B_TO_A
        address_A = 7'd20; address_B = 7'd21; swap = 1'b1;
        tick();
        swap = 1'b0;
        reset_n = 1'b0;
        #2;
        model_reset();
`ifdef SWAP_REG_FILE_MEM_RESET_EN
        read_const("rst_mid_20", 20, 8'h00);
        read_const("rst_mid_28", 28, 8'h00);
`endif
        sweep_all("rst_mid_sweep");
        @(negedge clk);
        reset_n = 1'b1;
        we = 1'b1; address_w = 7'd20; data_w = 8'h3C;
        tick();
        read_const("post_rst_wr", 20, 8'h3C);
        idle_inputs();
        tick();
        tick();
        read_const("post_rst_keep20", 20, 8'h3C);
        read_check("post_rst_21", 21);

        // Randomized traffic over a small address window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            we        = 1'($urandom_range(0, 1));
            swap      = ($urandom_range(0, 3) == 0);
            address_w = 7'($urandom_range(0, 15));
            data_w    = 8'($urandom);
            address_A = 7'($urandom_range(0, 15));
            address_B = 7'($urandom_range(0, 15));
            tick();
            read_check("rnd_rd", $urandom_range(0, 15));
            read_check("rnd_swap_a", sw_a);
        end
        idle_inputs();
        tick();
        tick();
        tick();
        sweep_all("final_sweep");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
